// File: rtl/mat_vec_mac_seq_if.sv
// Streaming, weight-load and status signals of mat_vec_mac_seq; master drives inputs, slave is the block.
interface mat_vec_mac_seq_if #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int DW   = 8
);
  localparam int RAW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CAW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                 w_we;
  logic [RAW-1:0]       w_row;
  logic [CAW-1:0]       w_col;
  logic signed [DW-1:0] w_data;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  logic                 busy;
  logic                 sat_flag;

  modport master (
    output w_we, w_row, w_col, w_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, sat_flag
  );

  modport slave (
    input  w_we, w_row, w_col, w_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, sat_flag
  );
endinterface

// File: rtl/mat_vec_mac_seq.sv
// Time-multiplexed signed y = sat(W*v) with LANES MACs; first result COLS+1 cycles after last input,
// output held until out_ready, no input taken while busy. Define MVM_RELU_EN to zero negative results.
module mat_vec_mac_seq #(
  parameter int ROWS  = 64,
  parameter int COLS  = 64,
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 2*DW + $clog2(COLS)
) (
  input logic              clk,
  input logic              rstn,
  mat_vec_mac_seq_if.slave bus
);

  localparam int NGRP = ROWS / LANES;
  localparam int RAW  = (ROWS > 1)  ? $clog2(ROWS)  : 1;
  localparam int CW   = (COLS > 1)  ? $clog2(COLS)  : 1;
  localparam int GW   = (NGRP > 1)  ? $clog2(NGRP)  : 1;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2**(DW-1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2**(DW-1)));
  localparam logic signed [DW-1:0]   OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_SAT,
    S_DRAIN
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        col_q;
  logic [GW-1:0]        grp_q;
  logic [LW-1:0]        lane_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic signed [DW-1:0] out_data_q;
  logic                 busy_q;
  logic                 sat_q;

  logic signed [ACCW-1:0] acc_q [LANES];
  logic signed [ACCW-1:0] acc_d [LANES];
  logic signed [DW-1:0]   res_q [LANES];
  logic signed [DW-1:0]   res_d [LANES];
  logic signed [2*DW-1:0] prod  [LANES];
  logic                   sat_hit;

  // Weight RAM and captured input vector carry no reset: weights survive a mid-run reset.
  logic signed [DW-1:0] w_mem [ROWS][COLS];
  logic signed [DW-1:0] v_q   [COLS];

  logic          in_fire;
  logic          out_fire;
  logic          last_grp;
  logic          last_col;
  logic [LW-1:0] lane_nx;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;
  assign last_grp = (grp_q == GW'(NGRP - 1));
  assign last_col = (col_q == CW'(COLS - 1));
  assign lane_nx  = lane_q + 1'b1;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.sat_flag  = sat_q;

  function automatic logic [RAW-1:0] row_of(input logic [GW-1:0] g, input int l);
    return RAW'(int'(g) * LANES + l);
  endfunction

  // MAC lanes plus the clamp/ReLU stage that feeds the result registers in SAT.
  always_comb begin
    sat_hit = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = w_mem[row_of(grp_q, l)][col_q] * v_q[col_q];
      if (col_q == '0) begin
        acc_d[l] = ACCW'(prod[l]);
      end else begin
        acc_d[l] = acc_q[l] + ACCW'(prod[l]);
      end

      if (acc_q[l] > SAT_MAX) begin
        res_d[l] = OUT_MAX;
        sat_hit  = 1'b1;
      end else if (acc_q[l] < SAT_MIN) begin
        res_d[l] = OUT_MIN;
        sat_hit  = 1'b1;
      end else begin
        res_d[l] = acc_q[l][DW-1:0];
      end
`ifdef MVM_RELU_EN
      if (res_d[l][DW-1]) begin
        res_d[l] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (bus.w_we && !busy_q && int'(bus.w_row) < ROWS && int'(bus.w_col) < COLS) begin
      w_mem[bus.w_row][bus.w_col] <= bus.w_data;
    end
    if (in_fire) begin
      v_q[col_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      grp_q       <= '0;
      lane_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            busy_q <= 1'b1;
            if (state_q == S_IDLE) begin
              sat_q <= 1'b0;
            end
            if (last_col) begin
              col_q      <= '0;
              grp_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= S_COMPUTE;
            end else begin
              col_q   <= col_q + 1'b1;
              state_q <= S_LOAD;
            end
          end
        end

        S_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            acc_q[l] <= acc_d[l];
          end
          if (last_col) begin
            col_q   <= '0;
            state_q <= S_SAT;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end

        S_SAT: begin
          for (int l = 0; l < LANES; l++) begin
            res_q[l] <= res_d[l];
          end
          sat_q       <= sat_q | sat_hit;
          lane_q      <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= res_d[0];
          out_last_q  <= last_grp && (LANES == 1);
          state_q     <= S_DRAIN;
        end

        S_DRAIN: begin
          if (out_fire) begin
            if (lane_q == LW'(LANES - 1)) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              lane_q      <= '0;
              if (last_grp) begin
                grp_q      <= '0;
                busy_q     <= 1'b0;
                in_ready_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                grp_q   <= grp_q + 1'b1;
                state_q <= S_COMPUTE;
              end
            end else begin
              lane_q     <= lane_nx;
              out_data_q <= res_q[lane_nx];
              out_last_q <= last_grp && (lane_nx == LW'(LANES - 1));
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_mac_seq.sv
module tb_mat_vec_mac_seq;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int LANES = 2;
  localparam int RAW   = $clog2(ROWS);
  localparam int CAW   = $clog2(COLS);
  localparam int GRP_CYC = COLS + 1 + LANES;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mat_vec_mac_seq_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();

  mat_vec_mac_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(LANES)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int nchk = 0;
  int nerr = 0;
  int Wm [ROWS][COLS];
  int vv [COLS];
  int ey [ROWS];
  bit esat;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain dot products, clamp to DW signed range, optional ReLU.
  function automatic void model();
    esat = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      int s;
      s = 0;
      for (int j = 0; j < COLS; j++) s += Wm[i][j] * vv[j];
      if (s > 127) begin s = 127; esat = 1'b1; end
      else if (s < -128) begin s = -128; esat = 1'b1; end
`ifdef MVM_RELU_EN
      if (s < 0) s = 0;
`endif
      ey[i] = s;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.w_we   = 1'b1;
        bus.w_row  = RAW'(r);
        bus.w_col  = CAW'(c);
        bus.w_data = DW'(Wm[r][c]);
        cyc();
      end
    end
    bus.w_we = 1'b0;
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic send_vec(input bit wr_on_first, input bit hold_in);
    for (int j = 0; j < COLS; j++) begin
      int g;
      g = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(vv[j]);
      while (!bus.in_ready && g < 50) begin cyc(); g++; end
      if (g == 50) chk("in_ready_timeout", bus.in_ready, 1);
      if (j == 0 && wr_on_first) begin
        chk("busy_at_first_beat", bus.busy, 0);
        bus.w_we   = 1'b1;
        bus.w_row  = RAW'(ROWS - 1);
        bus.w_col  = CAW'(COLS - 1);
        bus.w_data = 8'sd99;
        Wm[ROWS-1][COLS-1] = 99;
      end
      cyc();
      bus.w_we = 1'b0;
    end
    if (!hold_in) bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input bit glitch_w, input string nm);
    int t;
    t = 0;
    model();
    if (glitch_w) begin
      bus.w_we   = 1'b1;
      bus.w_row  = '0;
      bus.w_col  = '0;
      bus.w_data = DW'(Wm[0][0] + 37);
      cyc();
      t++;
      bus.w_we = 1'b0;
    end
    for (int i = 0; i < ROWS; i++) begin
      int g;
      g = 0;
      while (!bus.out_valid && g < 200) begin cyc(); t++; g++; end
      if (g == 200) chk({nm, "_out_valid_timeout"}, bus.out_valid, 1);
      if (i == 0) chk({nm, "_first_latency"}, t, COLS + 1);
      if (i == 0 && stall > 0) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
          cyc();
          t++;
          chk({nm, "_stall_valid"}, bus.out_valid, 1);
          chk({nm, "_stall_data"}, $signed(bus.out_data), ey[0]);
        end
        bus.out_ready = 1'b1;
      end
      chk($sformatf("%s_y%0d", nm, i), $signed(bus.out_data), ey[i]);
      chk($sformatf("%s_last%0d", nm, i), bus.out_last, (i == ROWS - 1) ? 1 : 0);
      if (i == ROWS - 1) bus.in_valid = 1'b0;
      cyc();
      t++;
    end
    chk({nm, "_total_cycles"}, t, (ROWS / LANES) * GRP_CYC + stall);
    chk({nm, "_busy_end"}, bus.busy, 0);
    chk({nm, "_sat_flag"}, bus.sat_flag, esat ? 1 : 0);
  endtask

  task automatic set_diag(input int d);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) Wm[r][c] = (r == c) ? d : 0;
  endtask

  task automatic set_all(input int w, input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) Wm[r][c] = w;
    for (int j = 0; j < COLS; j++) vv[j] = v;
  endtask

  task automatic set_rand();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) Wm[r][c] = rnd8();
    for (int j = 0; j < COLS; j++) vv[j] = rnd8();
  endtask

  initial begin
    rstn          = 1'b0;
    bus.w_we      = 1'b0;
    bus.w_row     = '0;
    bus.w_col     = '0;
    bus.w_data    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", $signed(bus.out_data), 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    rstn = 1'b1;
    cyc();
    chk("idle_in_ready", bus.in_ready, 1);

    set_diag(1);
    for (int j = 0; j < COLS; j++) vv[j] = j + 1;
    load_w();
    send_vec(0, 0);
    collect(0, 0, "ident");

    set_all(127, 127);
    load_w();
    send_vec(0, 0);
    collect(5, 0, "satpos");

    set_all(-128, 127);
    load_w();
    send_vec(0, 0);
    collect(0, 0, "satneg");

    set_diag(-1);
    for (int j = 0; j < COLS; j++) vv[j] = j + 1;
    load_w();
    send_vec(0, 0);
    collect(0, 0, "negident");

    set_rand();
    load_w();
    send_vec(0, 0);
    collect(0, 1, "wglitch");
    send_vec(0, 0);
    collect(0, 0, "wrepeat");

    set_rand();
    load_w();
    send_vec(1, 1);
    collect(2, 0, "holdin");

    set_rand();
    load_w();
    send_vec(0, 0);
    begin
      int g;
      g = 0;
      while (!bus.out_valid && g < 200) begin cyc(); g++; end
      chk("midrst_reach_drain", bus.out_valid, 1);
    end
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    cyc();
    rstn = 1'b1;
    cyc();
    for (int j = 0; j < COLS; j++) vv[j] = rnd8();
    send_vec(0, 0);
    collect(0, 0, "postrst");

    for (int k = 0; k < 3; k++) begin
      set_rand();
      load_w();
      send_vec(0, 0);
      collect(k, 0, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
